// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: shared widths, button indices and helpers
// for the pushbutton operand entry front-end.
package operand_entry_pkg;

  localparam int OP_W = 2;
  localparam int NBTN = 3;

  localparam int BTN_A   = 0;
  localparam int BTN_B   = 1;
  localparam int BTN_CLR = 2;

  typedef logic [OP_W-1:0] op_t;

  // Counter width able to hold n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_entry_btn_conditioner.sv
// btn_conditioner: synchroniser, debouncer, press edge detector
// and optional hold-to-repeat generator for one raw button.
module btn_conditioner #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_CYCLES = 25000000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  import operand_entry_pkg::*;

  localparam int DW = cnt_w(DB_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [DW-1:0] dcnt;
  logic          rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      dcnt <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        dcnt <= '0;
      end else if (dcnt == DB_MAX) begin
        db   <= ~db;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign rise = db & ~db_q;

  generate
    if (REPEAT_EN && (REPEAT_CYCLES > 0)) begin : g_rpt
      localparam int RW = cnt_w(REPEAT_CYCLES);
      localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

      logic [RW-1:0] rcnt;
      logic          rpt;

      // Counting starts the cycle after the press pulse, so the
      // first repeat lands a full period after it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt <= '0;
        end else if (!(db && db_q) || (rcnt == RPT_MAX)) begin
          rcnt <= '0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end

      assign rpt   = db & db_q & (rcnt == RPT_MAX);
      assign press = rise | rpt;
    end else begin : g_norpt
      assign press = rise;
    end
  endgenerate

endmodule

// File: rtl/operand_entry.sv
// operand_entry: conditions three buttons and steps the two
// operand registers feeding the multiplier display stage.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_a,
  input  logic            btn_b,
  input  logic            btn_clr,
  output logic [OP_W-1:0] a,
  output logic [OP_W-1:0] b,
  output logic            upd
);

  logic [NBTN-1:0] press;

  btn_conditioner #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .REPEAT_EN    (1'b1)
  ) u_btn_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_a),
    .press(press[BTN_A])
  );

  btn_conditioner #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .REPEAT_EN    (1'b1)
  ) u_btn_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_b),
    .press(press[BTN_B])
  );

  btn_conditioner #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .REPEAT_EN    (1'b0)
  ) u_btn_clr (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_clr),
    .press(press[BTN_CLR])
  );

  // Clear wins over any step arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      upd <= 1'b0;
    end else begin
      upd <= |press;
      if (press[BTN_CLR]) begin
        a <= '0;
        b <= '0;
      end else begin
        if (press[BTN_A]) a <= a + 1'b1;
        if (press[BTN_B]) b <= b + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed and random button traffic checked
// against a run-length / press-age model of the operand front-end.
module tb_operand_entry;
  import operand_entry_pkg::*;

  localparam int DB = 4;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic       btn_clr = 1'b0;
  logic [1:0] a;
  logic [1:0] b;
  logic       upd;

  int vectors = 0;
  int errors = 0;
  int updcnt = 0;

  operand_entry #(
    .DB_CYCLES    (DB),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_a  (btn_a),
    .btn_b  (btn_b),
    .btn_clr(btn_clr),
    .a      (a),
    .b      (b),
    .upd    (upd)
  );

  always #5 clk = ~clk;

  logic [2:0] raw;
  assign raw = {btn_clr, btn_b, btn_a};

  // Model: db flips after DB consecutive disagreeing samples;
  // a press fires when db rose, and every RP cycles of hold.
  logic       m_s1 [3];
  logic       m_s2 [3];
  logic       m_db [3];
  int         m_run[3];
  int         m_age[3];
  logic [1:0] ma = 2'd0;
  logic [1:0] mb = 2'd0;
  logic       mupd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [2:0] p;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 1'b0;
        m_s2[i] = 1'b0;
        m_db[i] = 1'b0;
        m_run[i] = 0;
        m_age[i] = 0;
      end
      ma = 2'd0;
      mb = 2'd0;
      mupd = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        p[i] = m_db[i] && (m_age[i] == 0 ||
               (i != BTN_CLR && (m_age[i] % RP) == 0));
      end
      mupd = |p;
      if (p[BTN_CLR]) begin
        ma = 2'd0;
        mb = 2'd0;
      end else begin
        ma = ma + 2'(p[BTN_A]);
        mb = mb + 2'(p[BTN_B]);
      end
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_db[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DB) begin
          m_db[i] = ~m_db[i];
          m_run[i] = 0;
          m_age[i] = 0;
        end else begin
          m_age[i]++;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  end

  always @(posedge clk) begin
    #2;
    vectors++;
    if (upd) updcnt++;
    assert ({a, b, upd} === {ma, mb, mupd}) else begin
      errors++;
      $error("FAIL model a/b/upd obs=%h exp=%h",
             {a, b, upd}, {ma, mb, mupd});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    {btn_clr, btn_b, btn_a} = m;
    tick(hold);
    {btn_clr, btn_b, btn_a} = 3'b000;
    tick(12);
  endtask

  initial begin
    int u0;
    logic [2:0] m;
    rst_n = 1'b0;
    tick(2);
    chk("reset", {a, b, upd}, 0);
    rst_n = 1'b1;
    tick(2);

    // single press: first sample at edge 0
    btn_a = 1'b1;
    tick(6);
    chk("press_pre", {a, upd}, {2'd0, 1'b0});
    tick(1);
    chk("press_step", {a, upd}, {2'd1, 1'b1});
    tick(1);
    chk("press_upd_one", upd, 0);
    btn_a = 1'b0;
    tick(12);

    // async reset mid-count with btn_a held
    btn_a = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {a, b, upd}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("rst_rearm_pre", a, 0);
    tick(1);
    chk("rst_rearm_step", {a, upd}, {2'd1, 1'b1});
    btn_a = 1'b0;
    tick(12);

    // glitch rejection
    u0 = updcnt;
    btn_b = 1'b1;
    tick(3);
    btn_b = 1'b0;
    tick(12);
    chk("glitch_b", b, 0);
    chk("glitch_upd", updcnt - u0, 0);

    press(3'b100, 7);
    chk("clear", {a, b}, 0);

    // wrap 1,2,3,0
    u0 = updcnt;
    for (int k = 1; k <= 4; k++) begin
      press(3'b001, 7);
      chk("wrap", a, k % 4);
    end
    chk("wrap_upd", updcnt - u0, 4);

    press(3'b011, 7);
    press(3'b011, 7);
    press(3'b010, 7);
    chk("setup", {a, b}, {2'd2, 2'd3});

    // clear priority over simultaneous a
    u0 = updcnt;
    btn_a = 1'b1;
    btn_clr = 1'b1;
    tick(7);
    chk("clr_prio", {a, b, upd}, {2'd0, 2'd0, 1'b1});
    btn_a = 1'b0;
    btn_clr = 1'b0;
    tick(12);
    chk("clr_prio_upd", updcnt - u0, 1);

    // hold-to-repeat on b
    btn_b = 1'b1;
    tick(7);
    chk("rpt_1", b, 1);
    tick(8);
    chk("rpt_2", b, 2);
    tick(8);
    chk("rpt_3", b, 3);
    tick(8);
    chk("rpt_0", b, 0);
    btn_b = 1'b0;
    tick(15);
    chk("rpt_stop", b, 0);

    // random traffic
    repeat (60) begin
      m = 3'($urandom_range(0, 7));
      {btn_clr, btn_b, btn_a} = m;
      tick(int'($urandom_range(1, 20)));
      {btn_clr, btn_b, btn_a} = 3'($urandom_range(0, 7));
      tick(int'($urandom_range(1, 6)));
      {btn_clr, btn_b, btn_a} = 3'b000;
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      tick(int'($urandom_range(1, 16)));
    end
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
